// File: rtl/prog_updown_counter_mc_if.sv
// Register bus for the multi-channel up/down counter: active-low chip select and
// read/write strobes, {channel, reg} address, write data and registered read data.
interface prog_updown_counter_mc_if #(
  parameter int WIDTH   = 8,
  parameter int CH_BITS = 1
);
  logic               ncs;
  logic               nwr;
  logic               nrd;
  logic [CH_BITS+1:0] addr;
  logic [WIDTH-1:0]   din;
  logic [WIDTH-1:0]   dout;

  modport master (output ncs, nwr, nrd, addr, din, input dout);
  modport slave  (input ncs, nwr, nrd, addr, din, output dout);
endinterface

// File: rtl/prog_updown_counter_mc.sv
// Multi-channel programmable up/down counter. Each channel owns START/END/STEP/CTRL,
// a four-state FSM and a saturating counter; the top decodes the bus and muxes reads.
module prog_updown_counter_mc_ch #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr,
  input  logic [1:0]            i_rsel,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_start,
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_ec,
  output logic                  o_err,
  output logic                  o_dir,
  output logic [3:0][WIDTH-1:0] o_regs
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  state_t                r_state, w_nxt;
  logic [WIDTH-1:0]      r_start, r_end, r_step, r_count;
  logic [1:0]            r_ctrl;
  logic                  r_ec, r_err;
  logic [WIDTH-1:0]      w_cnt, w_up, w_dn;
  logic                  w_ec, w_err, w_bad, w_we;
  logic [WIDTH:0]        w_sum;
  logic signed [WIDTH:0] w_dif;

  // One extra bit on both paths so the clamp to END sees overflow/underflow
  assign w_sum = {1'b0, r_count} + {1'b0, r_step};
  assign w_dif = $signed({1'b0, r_count}) - $signed({1'b0, r_step});
  assign w_up  = (w_sum > {1'b0, r_end}) ? r_end : w_sum[WIDTH-1:0];
  assign w_dn  = (w_dif < $signed({1'b0, r_end})) ? r_end : w_dif[WIDTH-1:0];

  assign w_bad = (r_step == '0) || (r_ctrl[0] && (r_start > r_end)) ||
                 (!r_ctrl[0] && (r_start < r_end));
  assign w_we  = i_wr && (r_state != S_RUN);

  always_comb begin
    w_nxt = r_state;
    w_cnt = r_count;
    w_ec  = 1'b0;
    w_err = r_err;
    case (r_state)
      S_IDLE, S_DONE:
        if (i_start) begin
          if (w_bad) begin
            w_nxt = S_ERR;
            w_err = 1'b1;
          end else begin
            w_cnt = r_start;
            w_nxt = S_RUN;
          end
        end
      S_RUN:
        if (r_count == r_end) begin
          w_ec = 1'b1;
          if (r_ctrl[1]) w_cnt = r_start;
          else           w_nxt = S_DONE;
        end else begin
          w_cnt = r_ctrl[0] ? w_up : w_dn;
        end
      S_ERR:
        if (i_wr) begin
          w_nxt = S_IDLE;
          w_err = 1'b0;
        end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_ec    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_count <= w_cnt;
      r_ec    <= w_ec;
      r_err   <= w_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start <= '0;
      r_end   <= '0;
      r_step  <= '0;
      r_ctrl  <= '0;
    end else if (w_we) begin
      case (i_rsel)
        2'd0:    r_start <= i_wdata;
        2'd1:    r_end   <= i_wdata;
        2'd2:    r_step  <= i_wdata;
        default: r_ctrl  <= i_wdata[1:0];
      endcase
    end
  end

  assign o_count = r_count;
  assign o_ec    = r_ec;
  assign o_err   = r_err;
  assign o_dir   = r_ctrl[0];
  assign o_regs  = {{{(WIDTH-2){1'b0}}, r_ctrl}, r_step, r_end, r_start};
endmodule

module prog_updown_counter_mc #(
  parameter int WIDTH   = 8,
  parameter int CH_BITS = 1,
  localparam int CH     = 2**CH_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  prog_updown_counter_mc_if.slave bus,
  input  logic [CH-1:0]          start,
  output logic [CH*WIDTH-1:0]    count,
  output logic [CH-1:0]          ec,
  output logic [CH-1:0]          err,
  output logic [CH-1:0]          dir
);
  logic [CH-1:0][WIDTH-1:0]      w_cnt;
  logic [CH-1:0][3:0][WIDTH-1:0] w_regs;
  logic [CH_BITS-1:0]            w_ch;
  logic [1:0]                    w_rsel;
  logic                          w_wr, w_rd;
  logic [WIDTH-1:0]              r_dout;

  assign w_ch   = bus.addr[CH_BITS+1:2];
  assign w_rsel = bus.addr[1:0];
  assign w_wr   = !bus.ncs && !bus.nwr;
  // A simultaneous write strobe wins; the read is dropped
  assign w_rd   = !bus.ncs && !bus.nrd && bus.nwr;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    prog_updown_counter_mc_ch #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .i_wr    (w_wr && (w_ch == CH_BITS'(g))),
      .i_rsel  (w_rsel),
      .i_wdata (bus.din),
      .i_start (start[g]),
      .o_count (w_cnt[g]),
      .o_ec    (ec[g]),
      .o_err   (err[g]),
      .o_dir   (dir[g]),
      .o_regs  (w_regs[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_dout <= '0;
    else if (w_rd) r_dout <= w_regs[w_ch][w_rsel];
  end

  assign count    = w_cnt;
  assign bus.dout = r_dout;
endmodule

// File: doc/prog_updown_counter_mc.md
Name: prog_updown_counter_mc

Overview:
Multi-channel programmable up/down counter with a chip-select/read/write register bus. It is the parametrised successor of the single-channel 8-bit bus counter. Each channel has its own START, END, STEP and CTRL registers, its own start input, and independent count, ec, err and dir outputs. Channels support one-shot or auto-reload mode, saturate at END, and validate their configuration when started.

Parameters:
WIDTH, 8, data and count width per channel (>=2)
CH_BITS, 1, channel-select address bits; CH = 2**CH_BITS channels

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
ncs  input  1  chip select, active low
nwr  input  1  write strobe, active low
nrd  input  1  read strobe, active low
addr  input  CH_BITS+2  {channel, reg}; reg 0=START 1=END 2=STEP 3=CTRL
din  input  WIDTH  write data
dout  output  WIDTH  registered read data
start  input  CH  per-channel start request, level sampled
count  output  CH*WIDTH  channel i count at bits [i*WIDTH +: WIDTH]
ec  output  CH  end-of-count pulse, one cycle
err  output  CH  configuration error, sticky
dir  output  CH  CTRL[0] of each channel (1=up, 0=down)

Behaviour:
- Reset (reset=0, asynchronous): all registers, count, dout, ec and err go to 0; every channel enters IDLE.
- CTRL register: bit0 = dir (1=up), bit1 = reload (1=auto-reload). All other bits read back 0.
- Write: at a posedge with ncs=0 and nwr=0, the addressed register takes din.
  - A write to a channel in RUN is ignored.
  - A write to a channel in ERROR is performed, clears err and returns the channel to IDLE.
- Read: at a posedge with ncs=0, nrd=0 and nwr=1, dout takes the addressed register. Latency is 1 cycle. dout holds its value otherwise.
- ncs=0 with both nwr=0 and nrd=0: the write is performed and the read is ignored.
- ncs=1: bus strobes are ignored.
- Per-channel FSM states: IDLE, RUN, DONE, ERROR.
- IDLE/DONE with start[i]=1 at a posedge:
  - If STEP==0, or (up and START>END), or (down and START<END): go to ERROR, err<=1, count unchanged.
  - Otherwise: count<=START and go to RUN.
- RUN, when count!=END:
  - up: count <= min(count+STEP, END), computed in WIDTH+1 bits so no wrap.
  - down: count <= max(count-STEP, END), computed signed so no underflow.
- RUN, when count==END: ec<=1 for exactly one cycle.
  - reload=1: count<=START and stay in RUN.
  - reload=0: go to DONE and hold count.
- start is ignored in RUN and ERROR. Deasserting start does not stop a run; a run stops only at terminal count or on reset.
- START==END is a valid configuration: count=START, then ec on the next edge.
- Channels are fully independent. Simultaneous start on several channels is allowed.
- Reset mid-run aborts immediately to the reset values above.

Test Plan:
1. Ch0: START=10, END=15, STEP=2, CTRL=1, pulse start -> count at successive edges 10, 12, 14, 15; ec=1 for one cycle at the next edge; state DONE; count holds 15; dir[0]=1.
2. Ch1: START=20, END=5, STEP=7, CTRL=2 (down, reload), start -> 20, 13, 6, 5, then ec pulse with count=20, sequence repeats; ch0 stays idle at 0 throughout.
3. Saturation: START=250, END=255, STEP=4, up -> 250, 254, 255 with no wrap; then ec.
4. Error: START=15, END=10, up, start -> err=1, count unchanged, no ec. Then write CTRL=0 -> err=0, IDLE. Start again -> valid down run 15 to 10.
5. Bus: write START=0x3C to ch1, read addr {1,0} -> dout=0x3C one cycle after the read edge. Write END during RUN -> readback still shows the old value. Same write with ncs=1 -> ignored.
6. Reset: pull reset low mid-run, between clock edges -> count, ec, err and dout go to 0 immediately. After release, a start without reprogramming -> err=1, because STEP is now 0.
